ray_multi_normal_pipeline: RTL



---
 rtl/ray_multi_normal_pipeline.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ray_multi_normal_pipeline.sv
// Unnormalised surface normal for sphere / plane / axis-aligned box hits through one
// fixed-latency pipeline with valid/ready backpressure, tag sideband and illegal-type counting.
module ray_multi_normal_pipeline #(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int TAGW = 8,
    parameter int LAT  = 3,
    parameter int ECW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic [TAGW-1:0]   in_tag,
    input  logic [3*W-1:0]    obj_vec,
    input  logic [3*W-1:0]    hit_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3*W-1:0]    out_normal,
    output logic [1:0]        out_type,
    output logic [TAGW-1:0]   out_tag,
    output logic              out_err,
    output logic [ECW-1:0]    err_count
);

    typedef enum logic [1:0] {
        T_SPHERE  = 2'd0,
        T_PLANE   = 2'd1,
        T_BOX     = 2'd2,
        T_ILLEGAL = 2'd3
    } obj_type_e;

    typedef struct packed {
        logic            v;
        logic [3*W-1:0]  n;
        logic [1:0]      t;
        logic [TAGW-1:0] g;
        logic            e;
    } beat_t;

    // Stages 2..LAT; element 0 is stage 2, element NS-1 is the output register.
    localparam int NS = LAT - 1;
    localparam logic [W-1:0] UNIT = {{(W-1){1'b0}}, 1'b1} << FRAC;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic            s1_valid_q, s1_valid_d;
    logic [3*W-1:0]  s1_d_q, s1_d_d;
    logic [3*W-1:0]  s1_obj_q, s1_obj_d;
    obj_type_e       s1_type_q, s1_type_d;
    logic [TAGW-1:0] s1_tag_q, s1_tag_d;
    logic [ECW-1:0]  err_count_q, err_count_d;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d_d      = s1_d_q;
        s1_obj_d    = s1_obj_q;
        s1_type_d   = s1_type_q;
        s1_tag_d    = s1_tag_q;
        err_count_d = err_count_q;
        if (adv) begin
            s1_valid_d = in_valid;
            s1_d_d     = {hit_pos[3*W-1:2*W] - obj_vec[3*W-1:2*W],
                          hit_pos[2*W-1:W]   - obj_vec[2*W-1:W],
                          hit_pos[W-1:0]     - obj_vec[W-1:0]};
            s1_obj_d   = obj_vec;
            s1_type_d  = obj_type_e'(in_type);
            s1_tag_d   = in_tag;
            if (in_valid && obj_type_e'(in_type) == T_ILLEGAL && err_count_q != '1)
                err_count_d = err_count_q + ECW'(1);
        end
    end

    logic [W-1:0] dx, dy, dz, mx, my, mz;
    logic [1:0]   axis;
    logic         box_neg;

    // Magnitudes are unsigned W-bit, so the most negative value maps to 2^(W-1).
    always_comb begin
        dx = s1_d_q[3*W-1:2*W];
        dy = s1_d_q[2*W-1:W];
        dz = s1_d_q[W-1:0];
        mx = dx[W-1] ? -dx : dx;
        my = dy[W-1] ? -dy : dy;
        mz = dz[W-1] ? -dz : dz;
        if (mx >= my && mx >= mz) begin
            axis    = 2'd0;
            box_neg = dx[W-1];
        end else if (my >= mz) begin
            axis    = 2'd1;
            box_neg = dy[W-1];
        end else begin
            axis    = 2'd2;
            box_neg = dz[W-1];
        end
    end

    beat_t sel_beat;

    always_comb begin
        sel_beat   = '0;
        sel_beat.v = s1_valid_q;
        sel_beat.t = s1_type_q;
        sel_beat.g = s1_tag_q;
        case (s1_type_q)
            T_SPHERE: sel_beat.n = s1_d_q;
            T_PLANE:  sel_beat.n = s1_obj_q;
            T_BOX: begin
                case (axis)
                    2'd0:    sel_beat.n[3*W-1:2*W] = box_neg ? -UNIT : UNIT;
                    2'd1:    sel_beat.n[2*W-1:W]   = box_neg ? -UNIT : UNIT;
                    default: sel_beat.n[W-1:0]     = box_neg ? -UNIT : UNIT;
                endcase
            end
            T_ILLEGAL: sel_beat.e = 1'b1;
        endcase
    end

    beat_t [NS-1:0] beat_q, beat_d;
    beat_t [NS:0]   beat_ext;

    // Shifting through a one-wider concatenation keeps LAT = 2 (a single stage) legal.
    always_comb begin
        beat_ext = {beat_q, sel_beat};
        beat_d   = adv ? beat_ext[NS-1:0] : beat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_d_q      <= '0;
            s1_obj_q    <= '0;
            s1_type_q   <= T_SPHERE;
            s1_tag_q    <= '0;
            err_count_q <= '0;
            beat_q      <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_d_q      <= s1_d_d;
            s1_obj_q    <= s1_obj_d;
            s1_type_q   <= s1_type_d;
            s1_tag_q    <= s1_tag_d;
            err_count_q <= err_count_d;
            beat_q      <= beat_d;
        end
    end

    assign out_valid  = beat_q[NS-1].v;
    assign out_normal = beat_q[NS-1].n;
    assign out_type   = beat_q[NS-1].t;
    assign out_tag    = beat_q[NS-1].g;
    assign out_err    = beat_q[NS-1].e;
    assign err_count  = err_count_q;

endmodule
